// File: rtl/timer16_apb_regs.sv
// 16-bit up/down timer with prescaler behind an 8-bit APB register file, with programmable wait states.
// Build option: define TIMER_SNAPSHOT_EN so that a TCNT0 read latches TCNT1 for a coherent 16-bit read.
module timer16_apb_regs #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   output logic       tmr_ovf,
   output logic       tmr_udf
);

   localparam logic [2:0] WS = 3'(WAIT_STATES);

   logic        setup, access, err, wr_ok, rd_fire;
   logic        armed_reg;
   logic [2:0]  wcnt_reg;
   logic [7:0]  tdr0_reg, tdr1_reg, prdata_reg, rdata;
   logic        dir_reg, en_reg;
   logic [1:0]  cks_reg, tsr_reg, tsr_set, tsr_clr;
   logic [3:0]  psc_reg, psc_mask;
   logic [15:0] cnt_reg;
   logic        tick, tcr_wr, load;
   logic        unused_ok;

   assign setup   = psel & ~penable;
   assign access  = psel & penable;
   // armed is only set by a setup phase, so an access phase interrupted by reset never completes
   assign pready  = access & armed_reg & (wcnt_reg == WS);
   assign err     = (paddr > 8'h05) | (pwrite & ((paddr == 8'h04) | (paddr == 8'h05)));
   assign pslverr = pready & err;
   assign wr_ok   = pready & pwrite & ~err;
   assign rd_fire = pready & ~pwrite;
   assign prdata  = rd_fire ? rdata : prdata_reg;

   assign tcr_wr  = wr_ok & (paddr == 8'h02);
   assign load    = tcr_wr & pwdata[7];
   assign tsr_clr = (wr_ok && paddr == 8'h03) ? pwdata[1:0] : 2'b00;
   assign unused_ok = ^{pwdata[6], pwdata[3:2]};

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wcnt_reg  <= '0;
         armed_reg <= 1'b0;
      end else if (setup) begin
         wcnt_reg  <= '0;
         armed_reg <= 1'b1;
      end else if (access && armed_reg && !pready) begin
         wcnt_reg  <= wcnt_reg + 3'd1;
      end else begin
         wcnt_reg  <= '0;
         armed_reg <= 1'b0;
      end
   end

   // Divide-by-2^(cks+1): tick when the low cks+1 prescaler bits are all ones
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_mask
         assign psc_mask[gi] = (2'(gi) <= cks_reg);
      end
   endgenerate

   assign tick = en_reg & ((psc_reg & psc_mask) == psc_mask);

   always_comb begin
      tsr_set = 2'b00;
      if (tick && !load) begin
         tsr_set[0] = ~dir_reg & (cnt_reg == 16'hFFFF);
         tsr_set[1] =  dir_reg & (cnt_reg == 16'h0000);
      end
   end

`ifdef TIMER_SNAPSHOT_EN
   logic [7:0] shadow_reg;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset)
         shadow_reg <= '0;
      else if (rd_fire && paddr == 8'h04)
         shadow_reg <= cnt_reg[15:8];
   end
`endif

   always_comb begin
      rdata = 8'h00;
      case (paddr)
         8'h00: rdata = tdr0_reg;
         8'h01: rdata = tdr1_reg;
         8'h02: rdata = {2'b00, dir_reg, en_reg, 2'b00, cks_reg};
         8'h03: rdata = {6'b0, tsr_reg};
         8'h04: rdata = cnt_reg[7:0];
`ifdef TIMER_SNAPSHOT_EN
         8'h05: rdata = shadow_reg;
`else
         8'h05: rdata = cnt_reg[15:8];
`endif
         default: rdata = 8'h00;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         tdr0_reg   <= '0;
         tdr1_reg   <= '0;
         dir_reg    <= 1'b0;
         en_reg     <= 1'b0;
         cks_reg    <= '0;
         tsr_reg    <= '0;
         psc_reg    <= '0;
         cnt_reg    <= '0;
         prdata_reg <= '0;
      end else begin
         if (wr_ok && paddr == 8'h00) tdr0_reg <= pwdata;
         if (wr_ok && paddr == 8'h01) tdr1_reg <= pwdata;
         if (tcr_wr) begin
            dir_reg <= pwdata[5];
            en_reg  <= pwdata[4];
            cks_reg <= pwdata[1:0];
         end
         // a set in the same cycle as a write-1-to-clear wins
         tsr_reg <= (tsr_reg & ~tsr_clr) | tsr_set;
         psc_reg <= en_reg ? psc_reg + 4'd1 : 4'd0;
         if (load)
            cnt_reg <= {tdr1_reg, tdr0_reg};
         else if (tick)
            cnt_reg <= dir_reg ? cnt_reg - 16'd1 : cnt_reg + 16'd1;
         if (rd_fire) prdata_reg <= rdata;
      end
   end

   assign tmr_ovf = tsr_reg[0];
   assign tmr_udf = tsr_reg[1];

endmodule
